// File: rtl/reaction_fsm.sv
// reaction_fsm: controller for the reaction-time game.
// Sequences idle/high-score display, random pre-delay, reaction window and
// score display over ROUNDS rounds; tracks the best score since reset.
// Optional feature macro: REACT_FALSE_START_EN (pressing during the pre-delay
// ends the round in FAULT). Without it, presses during the pre-delay are ignored.
module reaction_fsm #(
  parameter int CNT_W  = 14,
  parameter int ROUNDS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_start_n,
  input  logic             key_clr_n,
  input  logic             delay_done,
  input  logic             tick_ms,
  output logic             downcount_en,
  output logic             count_en,
  output logic             led_en,
  output logic             hiscore_en,
  output logic [CNT_W-1:0] score,
  output logic [CNT_W-1:0] hiscore,
  output logic             new_record,
  output logic             fault,
  output logic [3:0]       round_idx
);

  typedef enum logic [2:0] {IDLE, ARM, REACT, SHOW, FAULT} state_t;

  localparam logic [CNT_W-1:0] SCORE_MAX = '1;
  localparam logic [3:0]       LAST_RND  = 4'(ROUNDS - 1);

  // Key synchronisers: [0],[1] are the 2-flop synchroniser, [2] is the edge
  // history. The history bit only loads once warm[1] shows that [1] holds a
  // real sample, so a key held through reset release never looks like a press.
  logic [2:0] start_sync_reg, clr_sync_reg;
  logic [1:0] warm_reg;
  logic       start_p, clr_p;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] score_reg, score_next;
  logic [CNT_W-1:0] hiscore_reg, hiscore_next;
  logic             new_reg, new_next;
  logic             fault_reg, fault_next;
  logic [3:0]       round_reg, round_next;
  logic [CNT_W-1:0] react_score;

  // Synchronise both keys and register a one-cycle pulse on each falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_reg       <= 2'b00;
      start_sync_reg <= 3'b011;
      clr_sync_reg   <= 3'b011;
      start_p        <= 1'b0;
      clr_p          <= 1'b0;
    end else begin
      warm_reg       <= {warm_reg[0], 1'b1};
      start_sync_reg <= {start_sync_reg[1] & warm_reg[1], start_sync_reg[0], key_start_n};
      clr_sync_reg   <= {clr_sync_reg[1] & warm_reg[1], clr_sync_reg[0], key_clr_n};
      start_p        <= start_sync_reg[2] & ~start_sync_reg[1];
      clr_p          <= clr_sync_reg[2] & ~clr_sync_reg[1];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      score_reg   <= '0;
      hiscore_reg <= '1;
      new_reg     <= 1'b0;
      fault_reg   <= 1'b0;
      round_reg   <= 4'd0;
    end else begin
      state_reg   <= state_next;
      score_reg   <= score_next;
      hiscore_reg <= hiscore_next;
      new_reg     <= new_next;
      fault_reg   <= fault_next;
      round_reg   <= round_next;
    end
  end

  // Next-state logic; priority is clear > start > delay_done > tick, except that
  // a tick landing with the react press is still counted.
  always_comb begin
    state_next   = state_reg;
    score_next   = score_reg;
    hiscore_next = hiscore_reg;
    new_next     = new_reg;
    fault_next   = fault_reg;
    round_next   = round_reg;
    // Score as it stands after this cycle's tick, saturating at all ones.
    react_score  = (tick_ms && (score_reg != SCORE_MAX)) ? score_reg + 1'b1 : score_reg;

    if (clr_p) begin
      state_next = IDLE;
      round_next = 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_p) begin
            score_next = '0;
            new_next   = 1'b0;
            fault_next = 1'b0;
            round_next = 4'd0;
            state_next = ARM;
          end
        end
        ARM: begin
`ifdef REACT_FALSE_START_EN
          if (start_p) begin
            fault_next = 1'b1;
            state_next = FAULT;
          end else if (delay_done) begin
            score_next = '0;
            state_next = REACT;
          end
`else
          if (delay_done) begin
            score_next = '0;
            state_next = REACT;
          end
`endif
        end
        REACT: begin
          score_next = react_score;
          if (react_score == SCORE_MAX) begin
            // Timeout: a saturated score never counts as a record.
            new_next   = 1'b0;
            state_next = SHOW;
          end else if (start_p) begin
            if (react_score < hiscore_reg) begin
              hiscore_next = react_score;
              new_next     = 1'b1;
            end else begin
              new_next     = 1'b0;
            end
            state_next = SHOW;
          end
        end
        SHOW, FAULT: begin
          if (start_p) begin
            if (round_reg == LAST_RND) begin
              state_next = IDLE;
            end else begin
              round_next = round_reg + 4'd1;
              new_next   = 1'b0;
              fault_next = 1'b0;
              state_next = ARM;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign hiscore_en   = (state_reg == IDLE);
  assign downcount_en = (state_reg == ARM);
  assign count_en     = (state_reg == REACT);
  assign led_en       = (state_reg == REACT);
  assign score        = score_reg;
  assign hiscore      = hiscore_reg;
  assign new_record   = new_reg;
  assign fault        = fault_reg;
  assign round_idx    = round_reg;

endmodule
